// File: rtl/serial_sub_unit.sv
// serial_sub_unit: bit-serial WIDTH-bit subtractor
// one full-subtract cell reused LSB-first over WIDTH cycles
module fsub_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic b_o
);
  assign d_o = x_i ^ y_i ^ bin_i;
  assign b_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
endmodule

module serial_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             cell_d, cell_b;
  logic [WIDTH-1:0] acc_nx;

  fsub_cell u_cell (
    .x_i  (x_q[0]),
    .y_i  (y_q[0]),
    .bin_i(brw_q),
    .d_o  (cell_d),
    .b_o  (cell_b)
  );

  assign acc_nx = {cell_d, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = x;
          y_d     = y;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_nx;
        x_d   = {1'b0, x_q[WIDTH-1:1]};
        y_d   = {1'b0, y_q[WIDTH-1:1]};
        brw_d = cell_b;
        // counter holds at LAST; the next load clears it
        if (cnt_q == LAST) begin
          diff_d  = acc_nx;
          bout_d  = cell_b;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) & rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign diff      = diff_q;
  assign bout      = bout_q;
endmodule
